seg_scan4: RTL and testbench



---
 rtl/seg_pkg.sv | 12 +
 rtl/scan_tick.sv | 28 ++
 rtl/seg_scan4.sv | 90 +++++++++
 tb/tb_seg_scan4.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the four-digit multiplexed display scanner.
// Digit enables are active-low throughout.
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    function automatic logic [3:0] an_onehot(input logic [1:0] dig);
        return ~(4'b0001 << dig);
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running prescaler: TICK is high for one cycle out of every SCAN_DIV.
// Kept generic so other multiplexed-display blocks can reuse it.
module scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int               CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign TICK = (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (TICK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan4.sv
// Four-digit display scanner: shadows a 16-bit value on LOAD and multiplexes its
// nibbles to the downstream 7-segment decoder with active-low digit enables.
module seg_scan4
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD,
    input  logic [15:0] VALUE,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  BLANK_IN,
    output logic        R3,
    output logic        R2,
    output logic        R1,
    output logic        R0,
    output logic        DP_ON,
    output logic [3:0]  AN
);

    logic        tick;
    logic [1:0]  dig;
    logic [15:0] val_q;
    logic [3:0]  dp_q;
    logic [3:0]  bl_q;
    logic [3:0]  nib_q;
    logic        lz_off;
    logic        upper_zero;
    logic        digit_off;

    scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick (
        .CLK (CLK),
        .RST (RST),
        .TICK(tick)
    );

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        lz_off     = 1'b0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (val_q[4*i +: 4] == 4'h0);
            if (dig == 2'(i)) begin
                lz_off = upper_zero;
            end
        end
        if (!LZ_BLANK) begin
            lz_off = 1'b0;
        end
    end

    // The tick cycle blanks every enable so the old and new digit never overlap.
    assign digit_off = bl_q[dig] | tick | lz_off;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dig   <= 2'd0;
            val_q <= 16'h0000;
            dp_q  <= 4'h0;
            bl_q  <= 4'h0;
            nib_q <= 4'h0;
            DP_ON <= 1'b0;
            AN    <= AN_OFF;
        end else begin
            if (LOAD) begin
                val_q <= VALUE;
                dp_q  <= DP_IN;
                bl_q  <= BLANK_IN;
            end
            if (tick) begin
                dig <= dig + 2'd1;
            end
            nib_q <= val_q[{dig, 2'b00} +: 4];
            if (digit_off) begin
                AN    <= AN_OFF;
                DP_ON <= 1'b0;
            end else begin
                AN    <= an_onehot(dig);
                DP_ON <= dp_q[dig];
            end
        end
    end

    assign {R3, R2, R1, R0} = nib_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Self-checking bench for seg_scan4 with SCAN_DIV = 4; one instance without and
// one with leading-zero suppression, both fed the same stimulus.
module tb_seg_scan4;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;

    logic       r3, r2, r1, r0, dp_on;
    logic [3:0] an;
    logic       z3, z2, z1, z0, zdp;
    logic [3:0] zan;

    int checks = 0;
    int passes = 0;

    // Model state: edges since the last reset edge, plus the shadowed inputs.
    int          n        = 0;
    logic [15:0] mv       = '0;
    logic [3:0]  mdp      = '0;
    logic [3:0]  mbl      = '0;
    bit          model_ok = 1'b0;
    logic [8:0]  exp0     = '0;
    logic [8:0]  exp1     = '0;

    always #5 clk = ~clk;

    seg_scan4 #(.SCAN_DIV(D), .LZ_BLANK(1'b0)) dut (
        .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value), .DP_IN(dp_in),
        .BLANK_IN(blank_in), .R3(r3), .R2(r2), .R1(r1), .R0(r0),
        .DP_ON(dp_on), .AN(an)
    );

    seg_scan4 #(.SCAN_DIV(D), .LZ_BLANK(1'b1)) dut_lz (
        .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value), .DP_IN(dp_in),
        .BLANK_IN(blank_in), .R3(z3), .R2(z2), .R1(z1), .R0(z0),
        .DP_ON(zdp), .AN(zan)
    );

    // Outputs after edge number 'edges' (counted from 0 after reset release),
    // packed as {nibble, dp, an}.
    function automatic logic [8:0] model_out(input bit lz, input int edges,
                                             input logic [15:0] v,
                                             input logic [3:0] dpv,
                                             input logic [3:0] blv);
        int         pos;
        int         d;
        logic [3:0] nib;
        bit         off;
        logic [3:0] an_e;
        logic       dp_e;
        pos  = edges % D;
        d    = (edges / D) % 4;
        nib  = 4'((v >> (4 * d)) & 16'h000F);
        off  = blv[d] || (pos == D - 1) || (lz && d != 0 && (v >> (4 * d)) == 16'h0000);
        an_e = off ? 4'hF : 4'(15 - (1 << d));
        dp_e = off ? 1'b0 : dpv[d];
        return {nib, dp_e, an_e};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n        = 0;
            mv       = '0;
            mdp      = '0;
            mbl      = '0;
            exp0     = {4'h0, 1'b0, 4'hF};
            exp1     = {4'h0, 1'b0, 4'hF};
            model_ok = 1'b1;
        end else begin
            exp0 = model_out(1'b0, n, mv, mdp, mbl);
            exp1 = model_out(1'b1, n, mv, mdp, mbl);
            if (load) begin
                mv  = value;
                mdp = dp_in;
                mbl = blank_in;
            end
            n++;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_nib",    {r3, r2, r1, r0}, exp0[8:5]);
            check("model_dp",     {3'b000, dp_on},  {3'b000, exp0[4]});
            check("model_an",     an,               exp0[3:0]);
            check("model_lz_nib", {z3, z2, z1, z0}, exp1[8:5]);
            check("model_lz_dp",  {3'b000, zdp},    {3'b000, exp1[4]});
            check("model_lz_an",  zan,              exp1[3:0]);
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        load     = 1'b1;
        value    = v;
        dp_in    = d;
        blank_in = b;
        @(negedge clk);
        load     = 1'b0;
        value    = 16'hDEAD;
        dp_in    = 4'hF;
        blank_in = 4'hF;
    endtask

    task automatic wait_an(input string name, input logic [3:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == target) found = 1'b1;
        end
        checks++;
        if (found) passes++;
        else $display("[TB] FAIL %s: AN never reached %b within 40 cycles", name, target);
    endtask

    initial begin
        logic [3:0] idle_seq [0:16];
        int c_hi, c_d1, c_d1_7, c_d2, c_d0, c_other, c_dp;
        bit aligned;

        idle_seq = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                     4'b1101, 4'b1101, 4'b1101, 4'b1111,
                     4'b1011, 4'b1011, 4'b1011, 4'b1111,
                     4'b0111, 4'b0111, 4'b0111, 4'b1111,
                     4'b1110};

        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
        repeat (2) @(negedge clk);
        check("rst_an",     an, 4'b1111);
        check("rst_nib",    {r3, r2, r1, r0}, 4'h0);
        check("rst_dp",     {3'b000, dp_on}, 4'h0);
        check("rst_lz_an",  zan, 4'b1111);

        // Idle scan after reset release.
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check($sformatf("idle_an%0d", i), an, idle_seq[i]);
            check($sformatf("idle_nib%0d", i), {r3, r2, r1, r0}, 4'h0);
        end

        // Value A3F5 with decimal point on digit 2.
        do_load(16'hA3F5, 4'b0100, 4'b0000);
        wait_an("a3f5_d2", 4'b1011);
        check("a3f5_d2_nib", {r3, r2, r1, r0}, 4'h3);
        check("a3f5_d2_dp",  {3'b000, dp_on}, 4'h1);
        wait_an("a3f5_d3", 4'b0111);
        check("a3f5_d3_nib", {r3, r2, r1, r0}, 4'hA);
        check("a3f5_d3_dp",  {3'b000, dp_on}, 4'h0);
        wait_an("a3f5_d0", 4'b1110);
        check("a3f5_d0_nib", {r3, r2, r1, r0}, 4'h5);
        wait_an("a3f5_d1", 4'b1101);
        check("a3f5_d1_nib", {r3, r2, r1, r0}, 4'hF);
        check("a3f5_d1_dp",  {3'b000, dp_on}, 4'h0);

        // Leading-zero suppression on 0070, then on 0000.
        do_load(16'h0070, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        c_hi = 0; c_d1 = 0; c_d1_7 = 0; c_d2 = 0; c_d0 = 0;
        for (int i = 0; i < 4 * D; i++) begin
            @(negedge clk);
            if (zan == 4'b0111 || zan == 4'b1011) c_hi++;
            if (zan == 4'b1101) c_d1++;
            if (zan == 4'b1101 && {z3, z2, z1, z0} == 4'h7) c_d1_7++;
            if (zan == 4'b1110 && {z3, z2, z1, z0} == 4'h0) c_d0++;
            if (an == 4'b1011) c_d2++;
        end
        check_int("lz_upper_lit",   c_hi,   0);
        check_int("lz_d1_lit",      c_d1,   3);
        check_int("lz_d1_shows7",   c_d1_7, 3);
        check_int("lz_d0_shows0",   c_d0,   3);
        check_int("nolz_d2_lit",    c_d2,   3);

        do_load(16'h0000, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        c_d0 = 0; c_other = 0;
        for (int i = 0; i < 4 * D; i++) begin
            @(negedge clk);
            if (zan == 4'b1110) c_d0++;
            else if (zan != 4'b1111) c_other++;
        end
        check_int("lz_zero_d0_lit", c_d0,    3);
        check_int("lz_zero_others", c_other, 0);

        // Forced blanking of digit 1, which also carries a decimal point request.
        do_load(16'h1234, 4'b0010, 4'b0010);
        repeat (2) @(negedge clk);
        c_d1 = 0; c_dp = 0; c_d2 = 0;
        for (int i = 0; i < 4 * D; i++) begin
            @(negedge clk);
            if (an == 4'b1101) c_d1++;
            if (dp_on) c_dp++;
            if (an == 4'b1011) c_d2++;
        end
        check_int("blank_d1_never", c_d1, 0);
        check_int("blank_dp_off",   c_dp, 0);
        check_int("blank_d2_lit",   c_d2, 3);

        // LOAD on the tick that moves from digit 0 to digit 1.
        do_load(16'h0000, 4'b0000, 4'b0000);
        aligned = 1'b0;
        for (int i = 0; i < 40 && !aligned; i++) begin
            if (n % (4 * D) == D - 1) aligned = 1'b1;
            else @(negedge clk);
        end
        check_int("tick_align", int'(aligned), 1);
        load = 1'b1; value = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000;
        @(negedge clk);
        load = 1'b0; value = 16'hDEAD;
        check("tick_gap_an",  an, 4'b1111);
        check("tick_gap_nib", {r3, r2, r1, r0}, 4'h0);
        @(negedge clk);
        check("tick_new_an",  an, 4'b1101);
        check("tick_new_nib", {r3, r2, r1, r0}, 4'h3);

        // Reset in the middle of the digit-2 slot.
        wait_an("pre_rst_d2", 4'b1011);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an",    an, 4'b1111);
        check("midrst_nib",   {r3, r2, r1, r0}, 4'h0);
        check("midrst_dp",    {3'b000, dp_on}, 4'h0);
        check("midrst_lz_an", zan, 4'b1111);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_an",  an, 4'b1110);
        check("post_rst_nib", {r3, r2, r1, r0}, 4'h0);
        repeat (8) @(negedge clk);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
